alu_seq_arb: RTL and testbench
==============================

ALU_SEQ_ARB -- requirements
Module: alu_seq_arb

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal 2..16).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req0_valid, req1_valid  in  1  operation request from requester 0/1.
REQ-005 SHALL have ports: req0_ready, req1_ready  out  1  request accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands.
REQ-007 SHALL have ports: req0_op, req1_op  in  1  0 = a+b, 1 = a-b.
REQ-008 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; together the result handshake.
REQ-009 SHALL have ports: rsp_id  out  1  granted requester; rsp_sum  out  WIDTH; rsp_cout  out  1; rsp_ovf  out  1.
REQ-010 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 In IDLE, reqN_ready SHALL be combinational: high only for the granted requester when its valid is high; both readys low in CALC and DONE.
REQ-013 A transfer SHALL occur on a clock edge with reqN_valid & reqN_ready; the block then latches a, b, op and id, and moves to CALC.
REQ-014 For sub, the latched b SHALL be ~b and the carry-in SHALL be 1; for add, b is unchanged and the carry-in is 0.
REQ-015 CALC SHALL compute one bit per cycle, LSB first, using a ripple carry register and a bit counter 0..WIDTH-1; after bit WIDTH-1 it SHALL go to DONE.
REQ-016 rsp_cout SHALL be the carry out of the MSB; rsp_ovf SHALL be the carry into the MSB XOR the carry out of the MSB, for both add and sub.
REQ-017 Latency: an accept at edge T SHALL yield rsp_valid high in the cycle after edge T+WIDTH (WIDTH CALC cycles).
REQ-018 In DONE, rsp_valid SHALL stay high and all rsp_* SHALL stay stable until rsp_valid & rsp_ready; the FSM then returns to IDLE.
REQ-019 A new accept SHALL be possible in the first IDLE cycle after the response handshake; there is no same-cycle accept and respond.
REQ-020 reqN_valid deasserting while reqN_ready is low SHALL be legal and SHALL have no effect.
REQ-021 Operand inputs SHALL be sampled only at accept; later changes SHALL NOT affect the result in flight.

Reset
REQ-022 Asserting rst (low) SHALL immediately force: state IDLE, bit counter 0, carry 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_ovf 0, rsp_id 0, busy 0, round-robin pointer "last = 1".
REQ-023 A reset in CALC or DONE SHALL discard the in-flight operation with no response; after release, operation resumes from IDLE on the next edge.

Configuration
REQ-024 Macro ALU_SEQ_ARB_RR_EN defined: round-robin. On simultaneous valids, grant the requester not granted last; the pointer updates on each accept (first grant after reset goes to 0).
REQ-025 Macro ALU_SEQ_ARB_RR_EN undefined: fixed priority. Requester 0 always wins ties; no pointer register exists.
REQ-026 A single valid SHALL be granted immediately in both modes.

Verification
REQ-027 WIDTH=4: req0 add a=3, b=5 -> after 4 CALC cycles rsp_sum=8, rsp_cout=0, rsp_ovf=1, rsp_id=0.
REQ-028 req1 sub a=7, b=1 -> rsp_sum=6, rsp_cout=1, rsp_ovf=0, rsp_id=1; sub a=8, b=1 -> rsp_sum=7, rsp_cout=1, rsp_ovf=1.
REQ-029 Both valids held high for 3 operations -> RR_EN: rsp_id sequence 0,1,0; without macro: 0,0,0.
REQ-030 rsp_ready held low for 5 cycles in DONE -> rsp_* stable, both readys low, busy=1; on release, IDLE follows and the next accept occurs one cycle later.
REQ-031 rst pulsed low during CALC bit 2 -> rsp_valid never rises for that operation; all outputs read 0 asynchronously; the next request completes normally.
REQ-032 Operands changed during CALC -> result matches the values latched at accept.

Source files
------------

// File: rtl/alu_seq_arb.sv
// alu_seq_arb: two-requester arbiter feeding a bit-serial add/sub unit.
// Define ALU_SEQ_ARB_RR_EN for round-robin; otherwise requester 0 has priority.
module alu_seq_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_op,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sel1;
  logic             take;
  logic             sel_op;
  logic             bit_s;
  logic             bit_c;

`ifdef ALU_SEQ_ARB_RR_EN
  logic last;

  // Round-robin grant: on a tie pick whoever was not granted last
  always_comb sel1 = req1_valid & (~req0_valid | ~last);
`else
  // Fixed priority grant: requester 0 wins ties
  always_comb sel1 = req1_valid & ~req0_valid;
`endif

  assign req0_ready = (state == IDLE) & req0_valid & ~sel1;
  assign req1_ready = (state == IDLE) & sel1;
  assign take       = req0_ready | req1_ready;
  assign sel_op     = sel1 ? req1_op : req0_op;

  // One full-adder slice on the current LSBs
  always_comb begin
    bit_s = opa[0] ^ opb[0] ^ carry;
    bit_c = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
  end

  // Control FSM with datapath and registered response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      res       <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_ovf   <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_SEQ_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            opa    <= sel1 ? req1_a : req0_a;
            opb    <= sel_op ? ~(sel1 ? req1_b : req0_b)
                             :  (sel1 ? req1_b : req0_b);
            carry  <= sel_op;
            cnt    <= '0;
            res    <= '0;
            rsp_id <= sel1;
            busy   <= 1'b1;
            state  <= CALC;
`ifdef ALU_SEQ_ARB_RR_EN
            last   <= sel1;
`endif
          end
        end
        CALC: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          res   <= {bit_s, res[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            rsp_sum   <= {bit_s, res[WIDTH-1:1]};
            rsp_cout  <= bit_c;
            rsp_ovf   <= carry ^ bit_c;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_arb.sv
// tb_alu_seq_arb: randomized and directed checks of alu_seq_arb.
// Expected arbitration depends on ALU_SEQ_ARB_RR_EN.
module tb_alu_seq_arb;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_op, req1_op;
  logic         rsp_valid, rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_ovf, busy;

  int checks = 0;
  int errors = 0;

  alu_seq_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic, returns {cout, ovf, sum}
  function automatic logic [W+1:0] model(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = a[W-1] ? ua - (1 << W) : ua;
    sb = b[W-1] ? ub - (1 << W) : ub;
    if (!op) begin
      ur = ua + ub;
      sr = sa + sb;
      co = (ur >= (1 << W));
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end
    ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return {co, ov, W'(ur)};
  endfunction

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one request, wait for accept and response, acknowledge it.
  task automatic issue(
    input logic v0, input logic v1,
    input logic [W-1:0] a0, input logic [W-1:0] b0, input logic o0,
    input logic [W-1:0] a1, input logic [W-1:0] b1, input logic o1,
    input bit hold,
    output int gid, output int waited, output int lat,
    output logic [W+2:0] rsp);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req0_op = o0;
    req1_a = a1; req1_b = b1; req1_op = o1;
    #1;
    gid = -1;
    waited = 0;
    for (int k = 0; k < 20; k++) begin
      if (req0_ready || req1_ready) begin
        gid = req1_ready ? 1 : 0;
        break;
      end
      @(posedge clk); #1;
      waited++;
    end
    lat = -1;
    rsp = '0;
    if (gid < 0) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
    end
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rsp = {rsp_id, rsp_cout, rsp_ovf, rsp_sum};
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy,
         req0_ready, req1_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0",
        {rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy});
    end
    checks++;
    if (rsp_sum !== '0) begin
      errors++;
      $display("FAIL reset_sum got %h exp 0", rsp_sum);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_directed();
    int g, wt, l;
    logic [W+2:0] r;
    issue(1, 0, 4'd3, 4'd5, 0, 4'd0, 4'd0, 0, 0, g, wt, l, r);
    checks++;
    if (g !== 0 || l !== W) begin
      errors++;
      $display("FAIL add35_timing got id %0d lat %0d exp 0 %0d", g, l, W);
    end
    checks++;
    if (r !== {1'b0, 1'b0, 1'b1, 4'd8}) begin
      errors++;
      $display("FAIL add35 got %b exp %b", r, {1'b0, 1'b0, 1'b1, 4'd8});
    end
    issue(0, 1, 4'd0, 4'd0, 0, 4'd7, 4'd1, 1, 0, g, wt, l, r);
    checks++;
    if (g !== 1 || l !== W || wt !== 0) begin
      errors++;
      $display("FAIL sub71_timing got id %0d lat %0d wait %0d", g, l, wt);
    end
    checks++;
    if (r !== {1'b1, 1'b1, 1'b0, 4'd6}) begin
      errors++;
      $display("FAIL sub71 got %b exp %b", r, {1'b1, 1'b1, 1'b0, 4'd6});
    end
    issue(0, 1, 4'd0, 4'd0, 0, 4'd8, 4'd1, 1, 0, g, wt, l, r);
    checks++;
    if (r !== {1'b1, 1'b1, 1'b1, 4'd7}) begin
      errors++;
      $display("FAIL sub81 got %b exp %b", r, {1'b1, 1'b1, 1'b1, 4'd7});
    end
  endtask

  task automatic test_back_to_back();
    int g, wt, l;
    logic [W+2:0] r;
    logic [W-1:0] a0, b0, a1, b1;
    logic o0, o1;
    int ids[3];
`ifdef ALU_SEQ_ARB_RR_EN
    ids = '{0, 1, 0};
`else
    ids = '{0, 0, 0};
`endif
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      a0 = W'($urandom); b0 = W'($urandom); o0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); o1 = 1'($urandom);
      issue(1, 1, a0, b0, o0, a1, b1, o1, 1, g, wt, l, r);
      checks++;
      if (g !== ids[i] || l !== W || wt !== 0) begin
        errors++;
        $display("FAIL arb_%0d got id %0d lat %0d wait %0d exp id %0d",
          i, g, l, wt, ids[i]);
      end
      checks++;
      if (r !== {1'(ids[i]), (ids[i] == 1) ? model(a1, b1, o1)
                                           : model(a0, b0, o0)}) begin
        errors++;
        $display("FAIL arb_rsp_%0d got %b", i, r);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [W+2:0] snap, cur;
    int n;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 4'd2; req0_b = 4'd9; req0_op = 1'b0;
    @(posedge clk); #1;
    req0_a = 4'd1; req0_b = 4'd1; req0_op = 1'b1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    snap = {rsp_id, rsp_cout, rsp_ovf, rsp_sum};
    checks++;
    if (snap !== {1'b0, model(4'd2, 4'd9, 1'b0)} || n !== W) begin
      errors++;
      $display("FAIL stall_rsp got %b lat %0d", snap, n);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cur = {rsp_id, rsp_cout, rsp_ovf, rsp_sum};
      checks++;
      if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
          cur !== snap) begin
        errors++;
        $display("FAIL stall_hold_%0d got %b %b exp 1100 %b", i,
          {rsp_valid, busy, req0_ready, req1_ready}, cur, snap);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, busy, req0_ready} !== 3'b001) begin
      errors++;
      $display("FAIL stall_release got %b exp 001",
        {rsp_valid, busy, req0_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checks++;
    if ({busy, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL stall_next_accept got %b exp 10", {busy, req0_ready});
    end
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ({rsp_id, rsp_cout, rsp_ovf, rsp_sum} !==
        {1'b0, model(4'd1, 4'd1, 1'b1)}) begin
      errors++;
      $display("FAIL stall_second got %b",
        {rsp_id, rsp_cout, rsp_ovf, rsp_sum});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g, wt, l;
    bit seen;
    logic [W+2:0] r;
    req1_valid = 1'b1; req0_valid = 1'b0;
    req1_a = 4'd5; req1_b = 4'd6; req1_op = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy, req0_ready,
         req1_ready, rsp_sum} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b %h",
        {rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy}, rsp_sum);
    end
    #3;
    rst = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_rsp got %b exp 0", seen);
    end
    issue(1, 0, 4'd9, 4'd12, 1, 4'd0, 4'd0, 0, 0, g, wt, l, r);
    checks++;
    if (r !== {1'b0, model(4'd9, 4'd12, 1'b1)} || l !== W) begin
      errors++;
      $display("FAIL midreset_recover got %b lat %0d", r, l);
    end
  endtask

  task automatic test_random();
    int g, wt, l, eg, v;
    logic [W+2:0] r, e;
    logic [W-1:0] a0, b0, a1, b1;
    logic o0, o1;
    logic last;
    pulse_reset();
    last = 1'b1;
    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(1, 3));
      a0 = W'($urandom); b0 = W'($urandom); o0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); o1 = 1'($urandom);
      if (v == 3) begin
`ifdef ALU_SEQ_ARB_RR_EN
        eg = last ? 0 : 1;
`else
        eg = 0;
`endif
      end else begin
        eg = (v == 2) ? 1 : 0;
      end
      last = 1'(eg);
      e = {1'(eg), (eg == 1) ? model(a1, b1, o1) : model(a0, b0, o0)};
      issue(1'(v & 1), 1'(v >> 1), a0, b0, o0, a1, b1, o1, 0,
            g, wt, l, r);
      checks++;
      if (g !== eg || l !== W || r !== e) begin
        errors++;
        $display("FAIL rand_%0d got id %0d lat %0d rsp %b exp %0d %0d %b",
          i, g, l, r, eg, W, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_a = '0; req1_b = '0; req1_op = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
